esc_seq_encoder: RTL and testbench
==================================

ESC_SEQ_ENCODER -- requirements
Module: esc_seq_encoder

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port cmd_valid  input  1  command request present.
REQ-004 SHALL have port cmd_ready  output  1  encoder can accept a command.
REQ-005 SHALL have port cmd_type  input  4  command code per REQ-013.
REQ-006 SHALL have port pn1  input  8  first numeric parameter, unsigned 0..255.
REQ-007 SHALL have port pn2  input  8  second numeric parameter, unsigned 0..255.
REQ-008 SHALL have port pchar  input  8  raw byte for CHAR command.
REQ-009 SHALL have port tx_data  output  8  emitted byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  sink accepts byte when tx_valid && tx_ready.
REQ-012 SHALL have port busy  output  1  high while any sequence is in progress (state != IDLE).

Function
REQ-013 SHALL encode cmd_type: 0 CHAR -> pchar; 1 CUU -> ESC [ Pn1 A; 2 CUD -> ...B; 3 CUF -> ...C; 4 CUB -> ...D; 5 CUP -> ESC [ Pn1 ; Pn2 H; 6 CPR -> ESC [ Pn1 ; Pn2 R; 7 SGR -> ESC [ Pn1 m; 8 ED -> ESC [ Pn1 J; 9 EL -> ESC [ Pn1 K.
REQ-014 SHALL accept and discard codes 10..15 in one cycle, emitting no bytes.
REQ-015 SHALL assert cmd_ready only in IDLE; command latched (type, pn1, pn2, pchar) on the cycle cmd_valid && cmd_ready.
REQ-016 SHALL present the first byte with tx_valid high in the cycle after acceptance (latency 1).
REQ-017 SHALL advance one byte per cycle in which tx_valid && tx_ready; with tx_ready held high, an n-byte sequence occupies exactly n consecutive cycles.
REQ-018 SHALL hold tx_data stable and tx_valid high while tx_ready is low (no byte dropped or repeated).
REQ-019 SHALL use states IDLE, ESC, LBR, P1H, P1T, P1O, SEMI, P2H, P2T, P2O, FIN, CHR; transitions skip states not used by the latched command.
REQ-020 SHALL render each parameter as decimal ASCII (0x30+digit), leading zeros suppressed, value 0 rendered as "0"; hundreds digit emitted only if value>=100, tens only if value>=10.
REQ-021 SHALL compute digits from the latched 8-bit value without division (compare/subtract by 200/100, then tens); result exact for all 0..255.
REQ-022 SHALL return to IDLE on the cycle the final byte handshakes, with cmd_ready high that same next cycle; a new command may be accepted then (back-to-back, no bubble beyond one cycle).
REQ-023 SHALL ignore cmd_type/pn1/pn2/pchar changes while busy.
REQ-024 SHALL drive tx_data = 0x00 when tx_valid is low.

Reset
REQ-025 SHALL on rst force state IDLE, tx_valid 0, tx_data 0x00, busy 0, cmd_ready 1 (after release), latched registers 0.
REQ-026 SHALL abort any in-progress sequence on rst; no remaining bytes emitted after release.

Configuration
REQ-027 SHALL, with macro ESC_ENCODER_C1_CSI_EN defined, emit the single 8-bit C1 byte 0x9B in place of ESC (0x1B) followed by '[' (0x5B), skipping LBR; CHAR unaffected.
REQ-028 SHALL, without ESC_ENCODER_C1_CSI_EN, emit the two-byte 7-bit introducer 0x1B 0x5B.

Verification
REQ-029 SHALL check CUP pn1=12 pn2=5, tx_ready=1 -> 1B 5B 31 32 3B 35 48 in 7 consecutive cycles starting cycle after acceptance.
REQ-030 SHALL check CHAR pchar=0x41 then immediately CUU pn1=0 -> 41, then 1B 5B 30 41.
REQ-031 SHALL check CUF pn1=255 with tx_ready toggling 1,0,0,1,... -> 1B 5B 32 35 35 43, tx_data stable during stalls.
REQ-032 SHALL check CPR pn1=100 pn2=9 -> 1B 5B 31 30 30 3B 39 52; cmd_type=12 -> no bytes, cmd_ready high next cycle.
REQ-033 SHALL check rst asserted after 3rd byte of CUP 24,80 -> tx_valid 0 immediately, IDLE after release, next CHAR 0x7A -> 7A only.
REQ-034 SHALL check with ESC_ENCODER_C1_CSI_EN: CUP 1,1 -> 9B 31 3B 31 48.

Source files
------------

// File: rtl/esc_seq_encoder.sv
`default_nettype none
// ============================================================================
// Module      : esc_seq_encoder
// Description : Converts terminal-control commands into ANSI/VT100 escape
//               byte sequences. The sequences are emitted one byte at a time
//               over a valid/ready byte stream.
//
//               Commands (cmd_type):
//                 0 CHAR -> pchar
//                 1 CUU  -> CSI Pn1 A      2 CUD -> CSI Pn1 B
//                 3 CUF  -> CSI Pn1 C      4 CUB -> CSI Pn1 D
//                 5 CUP  -> CSI Pn1 ; Pn2 H
//                 6 CPR  -> CSI Pn1 ; Pn2 R
//                 7 SGR  -> CSI Pn1 m      8 ED  -> CSI Pn1 J
//                 9 EL   -> CSI Pn1 K
//                 10..15 -> accepted and dropped, no output
//               Each parameter is printed as decimal ASCII with no leading
//               zeros.
//
// Ports       : clk        rising-edge clock
//               rst        asynchronous active-high reset
//               cmd_valid  command request present
//               cmd_ready  encoder idle, can accept a command
//               cmd_type   command code (4 bits)
//               pn1, pn2   numeric parameters, 0..255
//               pchar      raw byte for CHAR
//               tx_data    emitted byte (0x00 whenever tx_valid is low)
//               tx_valid   tx_data valid
//               tx_ready   sink accepts the byte on tx_valid && tx_ready
//               busy       a sequence is in progress
//
// Macro       : ESC_ENCODER_C1_CSI_EN - when defined, the introducer is the
//               single 8-bit C1 byte 0x9B instead of ESC '['.
//
// Revision    : 1.0 - initial release
// ============================================================================
module esc_seq_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_type,
    input  logic [7:0] pn1,
    input  logic [7:0] pn2,
    input  logic [7:0] pchar,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
);

    // Each state corresponds to the byte currently being presented on tx_data.
    typedef enum logic [3:0] {
        IDLE = 4'd0,
        ESC  = 4'd1,
        LBR  = 4'd2,
        P1H  = 4'd3,
        P1T  = 4'd4,
        P1O  = 4'd5,
        SEMI = 4'd6,
        P2H  = 4'd7,
        P2T  = 4'd8,
        P2O  = 4'd9,
        FIN  = 4'd10,
        CHR  = 4'd11
    } state_t;

    localparam logic [7:0] c_BYTE_LBR  = 8'h5B;
    localparam logic [7:0] c_BYTE_SEMI = 8'h3B;
    localparam logic [7:0] c_ASCII_0   = 8'h30;

`ifdef ESC_ENCODER_C1_CSI_EN
    // The C1 CSI byte stands in for ESC '[', so the ESC state goes
    // directly to the first parameter.
    localparam logic [7:0] c_BYTE_INTRO = 8'h9B;
    localparam logic       c_SKIP_LBR   = 1'b1;
`else
    localparam logic [7:0] c_BYTE_INTRO = 8'h1B;
    localparam logic       c_SKIP_LBR   = 1'b0;
`endif

    state_t     r_state;
    logic [3:0] r_type;
    logic [7:0] r_pn1;
    logic [7:0] r_pn2;
    logic [7:0] r_pchar;
    logic [7:0] r_tx_data;
    logic       r_tx_valid;

    // Convert a binary value to decimal digits without a divider.
    // The hundreds digit comes from compare/subtract against 200 and 100.
    // The tens digit comes from a priority compare against 90..10.
    // The ones digit is what remains.
    // Returns {hundreds, tens, ones}, each 4 bits wide.
    function automatic logic [11:0] to_digits(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] h;
        logic [3:0] t;
        if (v >= 8'd200) begin
            h   = 4'd2;
            rem = v - 8'd200;
        end else if (v >= 8'd100) begin
            h   = 4'd1;
            rem = v - 8'd100;
        end else begin
            h   = 4'd0;
            rem = v;
        end
        t = 4'd0;
        for (int k = 9; k >= 1; k--) begin
            if (t == 4'd0 && rem >= 8'(k * 10)) begin
                t   = 4'(k);
                rem = rem - 8'(k * 10);
            end
        end
        return {h, t, rem[3:0]};
    endfunction

    logic [11:0] w_d1;
    logic [11:0] w_d2;
    logic        w_has_p2;
    logic [7:0]  w_final;
    state_t      w_p1_start;
    state_t      w_p2_start;
    state_t      w_nxt;
    logic [7:0]  w_nxt_byte;

    assign w_d1 = to_digits(r_pn1);
    assign w_d2 = to_digits(r_pn2);

    // Only CUP and CPR carry a second parameter.
    assign w_has_p2 = (r_type == 4'd5) || (r_type == 4'd6);

    // Leading-zero suppression: the number starts at the first nonzero
    // digit. The ones digit is always printed.
    assign w_p1_start = (w_d1[11:8] != 4'd0) ? P1H :
                        (w_d1[7:4]  != 4'd0) ? P1T : P1O;
    assign w_p2_start = (w_d2[11:8] != 4'd0) ? P2H :
                        (w_d2[7:4]  != 4'd0) ? P2T : P2O;

    always_comb begin
        w_final = 8'h00;
        case (r_type)
            4'd1:    w_final = 8'h41;   // A
            4'd2:    w_final = 8'h42;   // B
            4'd3:    w_final = 8'h43;   // C
            4'd4:    w_final = 8'h44;   // D
            4'd5:    w_final = 8'h48;   // H
            4'd6:    w_final = 8'h52;   // R
            4'd7:    w_final = 8'h6D;   // m
            4'd8:    w_final = 8'h4A;   // J
            4'd9:    w_final = 8'h4B;   // K
            default: w_final = 8'h00;
        endcase
    end

    // State that follows the current byte once it handshakes.
    always_comb begin
        w_nxt = IDLE;
        case (r_state)
            ESC:     w_nxt = c_SKIP_LBR ? w_p1_start : LBR;
            LBR:     w_nxt = w_p1_start;
            P1H:     w_nxt = P1T;       // tens is always printed after hundreds
            P1T:     w_nxt = P1O;
            P1O:     w_nxt = w_has_p2 ? SEMI : FIN;
            SEMI:    w_nxt = w_p2_start;
            P2H:     w_nxt = P2T;
            P2T:     w_nxt = P2O;
            P2O:     w_nxt = FIN;
            FIN:     w_nxt = IDLE;
            CHR:     w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    // Byte presented in the next state. IDLE maps to 0x00, so tx_data
    // returns to zero when the sequence ends.
    always_comb begin
        w_nxt_byte = 8'h00;
        case (w_nxt)
            ESC:     w_nxt_byte = c_BYTE_INTRO;
            LBR:     w_nxt_byte = c_BYTE_LBR;
            P1H:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d1[11:8]};
            P1T:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d1[7:4]};
            P1O:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d1[3:0]};
            SEMI:    w_nxt_byte = c_BYTE_SEMI;
            P2H:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d2[11:8]};
            P2T:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d2[7:4]};
            P2O:     w_nxt_byte = c_ASCII_0 + {4'd0, w_d2[3:0]};
            FIN:     w_nxt_byte = w_final;
            CHR:     w_nxt_byte = r_pchar;
            default: w_nxt_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_type     <= 4'd0;
            r_pn1      <= 8'h00;
            r_pn2      <= 8'h00;
            r_pchar    <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_type  <= cmd_type;
                        r_pn1   <= pn1;
                        r_pn2   <= pn2;
                        r_pchar <= pchar;
                        if (cmd_type == 4'd0) begin
                            r_state    <= CHR;
                            r_tx_data  <= pchar;
                            r_tx_valid <= 1'b1;
                        end else if (cmd_type <= 4'd9) begin
                            r_state    <= ESC;
                            r_tx_data  <= c_BYTE_INTRO;
                            r_tx_valid <= 1'b1;
                        end
                        // Codes 10..15 are absorbed here: the encoder stays
                        // idle and ready.
                    end
                end
                default: begin
                    // While tx_ready is low, all registers hold their values,
                    // so the presented byte stays stable.
                    if (tx_ready) begin
                        r_state    <= w_nxt;
                        r_tx_data  <= w_nxt_byte;
                        r_tx_valid <= (w_nxt != IDLE);
                    end
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;

endmodule
`default_nettype wire

// File: tb/tb_esc_seq_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_esc_seq_encoder
// Description : Self-checking bench for esc_seq_encoder. When a command is
//               driven, its expected bytes are queued. Each byte that
//               handshakes is compared against the head of the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esc_seq_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_type;
    logic [7:0] pn1;
    logic [7:0] pn2;
    logic [7:0] pchar;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    logic [7:0] q[$];
    int checks = 0;
    int errors = 0;

    esc_seq_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .pn1       (pn1),
        .pn2       (pn2),
        .pchar     (pchar),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_num(input logic [7:0] v);
        int iv;
        iv = int'(v);
        if (iv >= 100) q.push_back(8'(48 + iv / 100));
        if (iv >= 10)  q.push_back(8'(48 + (iv / 10) % 10));
        q.push_back(8'(48 + iv % 10));
    endtask

    // Reference model: queue the byte sequence a command should produce.
    task automatic model(input logic [3:0] t, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        logic [7:0] fin [10];
        fin = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h52, 8'h6D, 8'h4A, 8'h4B};
        if (t == 4'd0) begin
            q.push_back(c);
        end else if (t <= 4'd9) begin
`ifdef ESC_ENCODER_C1_CSI_EN
            q.push_back(8'h9B);
`else
            q.push_back(8'h1B);
            q.push_back(8'h5B);
`endif
            push_num(a);
            if (t == 4'd5 || t == 4'd6) begin
                q.push_back(8'h3B);
                push_num(b);
            end
            q.push_back(fin[t]);
        end
    endtask

    // Called at a falling edge. On return, the command has been accepted
    // and the time is the next falling edge.
    task automatic send(input logic [3:0] t, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c);
        check("cmd_ready_before_send", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_type  = t;
        pn1       = a;
        pn2       = b;
        pchar     = c;
        model(t, a, b, c);
        @(negedge clk);
        cmd_valid = 1'b0;
        // Change the command inputs after acceptance. The encoder must
        // ignore them.
        cmd_type  = 4'($urandom);
        pn1       = 8'($urandom);
        pn2       = 8'($urandom);
        pchar     = 8'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, tx_valid, 0);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_data"}, tx_data, 8'h00);
    endtask

    // tx_ready stays high. The bench expects one byte per cycle,
    // followed by IDLE.
    task automatic tight();
        int n;
        n = q.size();
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("tight_valid", tx_valid, 1);
            check("tight_busy", busy, 1);
            check("tight_data", tx_data, q.pop_front());
            @(negedge clk);
        end
        check_idle("tight_end");
    endtask

    // tx_ready follows the pattern 1,0,0,1. The presented byte must
    // hold through each stall.
    task automatic stalled();
        int         budget;
        int         k;
        logic       held_v;
        logic [7:0] held;
        budget = 200;
        k      = 0;
        held_v = 1'b0;
        held   = 8'h00;
        while ((q.size() > 0 || tx_valid) && budget > 0) begin
            tx_ready = (k % 4 == 0) || (k % 4 == 3);
            k++;
            if (held_v) begin
                check("stall_hold_data", tx_data, held);
                check("stall_hold_valid", tx_valid, 1);
            end
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) check("stall_extra_byte", tx_data, 32'hFFFF_FFFF);
                else check("stall_data", tx_data, q.pop_front());
                held_v = 1'b0;
            end else if (tx_valid) begin
                held   = tx_data;
                held_v = 1'b1;
            end
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("stall_timeout", 0, 1);
        tx_ready = 1'b1;
        check_idle("stall_end");
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = 4'd0;
        pn1       = 8'h00;
        pn2       = 8'h00;
        pchar     = 8'h00;
        tx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", tx_valid, 0);
        check("reset_data", tx_data, 8'h00);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        // CUP 12;5
        send(4'd5, 8'd12, 8'd5, 8'h00);
        tight();

        // CHAR 'A', then CUU 0 immediately after
        send(4'd0, 8'd0, 8'd0, 8'h41);
        tight();
        send(4'd1, 8'd0, 8'd0, 8'h00);
        tight();

        // CUF 255 under backpressure
        send(4'd3, 8'd255, 8'd0, 8'h00);
        stalled();

        // CPR 100;9, then a discarded code
        send(4'd6, 8'd100, 8'd9, 8'h00);
        tight();
        send(4'd12, 8'd77, 8'd88, 8'h55);
        tight();

        // Additional digit boundaries and final bytes
        send(4'd2, 8'd9, 8'd0, 8'h00);   tight();
        send(4'd4, 8'd10, 8'd0, 8'h00);  tight();
        send(4'd7, 8'd99, 8'd0, 8'h00);  stalled();
        send(4'd8, 8'd200, 8'd0, 8'h00); tight();
        send(4'd9, 8'd199, 8'd0, 8'h00); tight();
        send(4'd5, 8'd0, 8'd250, 8'h00); stalled();
        send(4'd15, 8'd1, 8'd2, 8'h03);  tight();

        // Reset in the middle of CUP 24;80, after the third byte
        send(4'd5, 8'd24, 8'd80, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("abort_pre_data", tx_data, q.pop_front());
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("abort_valid", tx_valid, 0);
        check("abort_data", tx_data, 8'h00);
        check("abort_busy", busy, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort_release");
        send(4'd0, 8'd0, 8'd0, 8'h7A);
        tight();

        // CUP 1;1. The expected introducer depends on the build.
        send(4'd5, 8'd1, 8'd1, 8'h00);
        tight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
